// File: rtl/pcap_buffer_ctrl.sv
// PCAP DMA buffer-table controller: FIFO of buffer base addresses,
// running DMA write address and coalesced capture interrupts.
module pcap_buffer_ctrl #(
    parameter int AW   = 3,
    parameter int BLKW = 16
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            addr_wr_i,
    input  logic [31:0]     addr_i,
    input  logic [BLKW-1:0] block_words_i,
    input  logic            arm_i,
    input  logic            disarm_i,
    input  logic            end_i,
    input  logic            beat_i,
    input  logic            irq_ack_i,
    output logic            active_o,
    output logic [31:0]     dma_addr_o,
    output logic [AW:0]     addr_level_o,
    output logic            irq_o,
    output logic [7:0]      irq_flags_o,
    output logic [BLKW-1:0] irq_count_o
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_ACTIVE = 1'b1;

    localparam int F_DONE  = 0;
    localparam int F_COMPL = 1;
    localparam int F_DISARM = 2;
    localparam int F_UNDER = 3;
    localparam int F_LOST  = 4;
    localparam int F_FULL  = 5;

    logic [31:0]     mem_q [DEPTH];
    logic [0:0]      state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic [31:0]     base_q, base_d;
    logic [BLKW-1:0] blk_q, blk_d;
    logic [BLKW-1:0] count_q, count_d;
    logic [31:0]     dma_addr_q, dma_addr_d;
    logic            irq_q, irq_d;
    logic [5:0]      flags_q, flags_d;
    logic [BLKW-1:0] irq_count_q, irq_count_d;

    logic            empty, full, pop, push_ok;
    logic [31:0]     head;
    logic [BLKW-1:0] cnt_inc, ev_cnt;
    logic [5:0]      ev_flags;

    always_comb begin
        empty    = (level_q == '0);
        full     = (level_q == FULL_LVL);
        head     = mem_q[rd_ptr_q];
        cnt_inc  = count_q + BLKW'(1);
        state_d  = state_q;
        base_d   = base_q;
        blk_d    = blk_q;
        count_d  = count_q;
        pop      = 1'b0;
        ev_flags = '0;
        ev_cnt   = '0;

        case (state_q)
            S_IDLE: begin
                if (arm_i && block_words_i != '0) begin
                    if (empty) begin
                        ev_flags[F_UNDER] = 1'b1;
                    end else begin
                        pop     = 1'b1;
                        base_d  = head;
                        blk_d   = block_words_i;
                        count_d = '0;
                        state_d = S_ACTIVE;
                    end
                end
            end
            S_ACTIVE: begin
                if (disarm_i) begin
                    ev_flags[F_DISARM] = 1'b1;
                    ev_cnt  = count_q;
                    state_d = S_IDLE;
                end else if (end_i) begin
                    ev_flags[F_COMPL] = 1'b1;
                    ev_cnt  = count_q + BLKW'(beat_i);
                    count_d = count_q + BLKW'(beat_i);
                    state_d = S_IDLE;
                end else if (beat_i) begin
                    count_d = cnt_inc;
                    if (cnt_inc == blk_q) begin
                        ev_flags[F_DONE] = 1'b1;
                        ev_cnt = blk_q;
                        // Rollover to the next buffer in the same cycle
                        if (!empty) begin
                            pop     = 1'b1;
                            base_d  = head;
                            count_d = '0;
                        end else begin
                            ev_flags[F_UNDER] = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        push_ok = addr_wr_i && (!full || pop);
        ev_flags[F_FULL] = addr_wr_i && full && !pop;

        wr_ptr_d   = wr_ptr_q + AW'(push_ok);
        rd_ptr_d   = rd_ptr_q + AW'(pop);
        level_d    = level_q + (AW+1)'(push_ok) - (AW+1)'(pop);
        dma_addr_d = base_d + (32'(count_d) << 2);

        irq_d       = irq_q;
        flags_d     = flags_q;
        irq_count_d = irq_count_q;
        if (ev_flags != '0) begin
            irq_d       = 1'b1;
            irq_count_d = ev_cnt;
            if (irq_q && !irq_ack_i)
                flags_d = flags_q | ev_flags | 6'(1 << F_LOST);
            else
                flags_d = ev_flags;
        end else if (irq_ack_i) begin
            irq_d       = 1'b0;
            flags_d     = '0;
            irq_count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok)
            mem_q[wr_ptr_q] <= {addr_i[31:2], 2'b00};
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            base_q      <= '0;
            blk_q       <= '0;
            count_q     <= '0;
            dma_addr_q  <= '0;
            irq_q       <= 1'b0;
            flags_q     <= '0;
            irq_count_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            base_q      <= base_d;
            blk_q       <= blk_d;
            count_q     <= count_d;
            dma_addr_q  <= dma_addr_d;
            irq_q       <= irq_d;
            flags_q     <= flags_d;
            irq_count_q <= irq_count_d;
        end
    end

    assign active_o     = (state_q == S_ACTIVE);
    assign dma_addr_o   = dma_addr_q;
    assign addr_level_o = level_q;
    assign irq_o        = irq_q;
    assign irq_flags_o  = {2'b00, flags_q};
    assign irq_count_o  = irq_count_q;

endmodule

// File: tb/tb_pcap_buffer_ctrl.sv
// Directed, table-driven bench for pcap_buffer_ctrl.
module tb_pcap_buffer_ctrl;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        addr_wr_i;
    logic [31:0] addr_i;
    logic [15:0] block_words_i;
    logic        arm_i, disarm_i, end_i, beat_i, irq_ack_i;
    logic        active_o;
    logic [31:0] dma_addr_o;
    logic [3:0]  addr_level_o;
    logic        irq_o;
    logic [7:0]  irq_flags_o;
    logic [15:0] irq_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    pcap_buffer_ctrl #(.AW(3), .BLKW(16)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .addr_wr_i(addr_wr_i), .addr_i(addr_i),
        .block_words_i(block_words_i),
        .arm_i(arm_i), .disarm_i(disarm_i), .end_i(end_i),
        .beat_i(beat_i), .irq_ack_i(irq_ack_i),
        .active_o(active_o), .dma_addr_o(dma_addr_o),
        .addr_level_o(addr_level_o), .irq_o(irq_o),
        .irq_flags_o(irq_flags_o), .irq_count_o(irq_count_o)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [15:0] blk;
        logic        arm, dis, en, beat, ack;
        logic        e_act;
        logic        dchk;
        logic [31:0] e_dma;
        logic [3:0]  e_lvl;
        logic        e_irq;
        logic [7:0]  e_flg;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic wr, logic [31:0] addr, logic [15:0] blk,
        logic arm, logic dis, logic en, logic beat, logic ack,
        logic e_act, logic dchk, logic [31:0] e_dma, logic [3:0] e_lvl,
        logic e_irq, logic [7:0] e_flg, logic [15:0] e_cnt);
        vec_t v;
        v.wr = wr; v.addr = addr; v.blk = blk;
        v.arm = arm; v.dis = dis; v.en = en; v.beat = beat; v.ack = ack;
        v.e_act = e_act; v.dchk = dchk; v.e_dma = e_dma;
        v.e_lvl = e_lvl; v.e_irq = e_irq; v.e_flg = e_flg; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        addr_wr_i = 0; addr_i = 0; block_words_i = 0;
        arm_i = 0; disarm_i = 0; end_i = 0; beat_i = 0; irq_ack_i = 0;
    endtask

    // Drive one cycle after a negedge, check #1 after the posedge.
    task automatic run(input vec_t v, input string nm);
        addr_wr_i = v.wr; addr_i = v.addr; block_words_i = v.blk;
        arm_i = v.arm; disarm_i = v.dis; end_i = v.en;
        beat_i = v.beat; irq_ack_i = v.ack;
        @(posedge clk_i);
        #1;
        chk({nm, ".active"}, 32'(active_o), 32'(v.e_act));
        if (v.dchk) chk({nm, ".dma"}, dma_addr_o, v.e_dma);
        chk({nm, ".level"}, 32'(addr_level_o), 32'(v.e_lvl));
        chk({nm, ".irq"}, 32'(irq_o), 32'(v.e_irq));
        chk({nm, ".flags"}, 32'(irq_flags_o), 32'(v.e_flg));
        chk({nm, ".count"}, 32'(irq_count_o), 32'(v.e_cnt));
        @(negedge clk_i);
        idle_inputs();
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".active"}, 32'(active_o), 0);
        chk({nm, ".dma"}, dma_addr_o, 0);
        chk({nm, ".level"}, 32'(addr_level_o), 0);
        chk({nm, ".irq"}, 32'(irq_o), 0);
        chk({nm, ".flags"}, 32'(irq_flags_o), 0);
        chk({nm, ".count"}, 32'(irq_count_o), 0);
    endtask

    task automatic do_reset();
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 0;
    endtask

    initial begin
        idle_inputs();
        reset_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        chk_zero("reset");
        @(negedge clk_i);
        reset_i = 0;

        // wr addr blk  arm dis en beat ack | act dchk dma lvl irq flg cnt
        tbl.push_back(mk(1,32'h1000,0, 0,0,0,0,0, 0,1,32'h0,   1,0,8'h00,0));
        tbl.push_back(mk(1,32'h2003,0, 0,0,0,0,0, 0,1,32'h0,   2,0,8'h00,0));
        tbl.push_back(mk(0,0,4,        1,0,0,0,0, 1,1,32'h1000,1,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h1004,1,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h1008,1,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h100C,1,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h2000,0,1,8'h01,4));
        tbl.push_back(mk(0,0,0,        0,0,0,1,1, 1,1,32'h2004,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h2008,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h200C,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 0,0,32'h0,   0,1,8'h09,4));
        tbl.push_back(mk(0,0,0,        0,0,0,0,1, 0,0,32'h0,   0,0,8'h00,0));
        tbl.push_back(mk(1,32'h1000,0, 0,0,0,0,0, 0,0,32'h0,   1,0,8'h00,0));
        tbl.push_back(mk(0,0,16,       1,0,0,0,0, 1,1,32'h1000,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h1004,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h1008,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h100C,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h1010,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,0,1,0, 1,1,32'h1014,0,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        0,0,1,1,0, 0,0,32'h0,   0,1,8'h02,6));
        tbl.push_back(mk(0,0,0,        0,0,0,0,1, 0,0,32'h0,   0,0,8'h00,0));
        tbl.push_back(mk(0,0,4,        1,0,0,0,0, 0,0,32'h0,   0,1,8'h08,0));
        tbl.push_back(mk(0,0,0,        0,0,0,0,1, 0,0,32'h0,   0,0,8'h00,0));
        tbl.push_back(mk(1,32'h3000,0, 0,0,0,0,0, 0,0,32'h0,   1,0,8'h00,0));
        tbl.push_back(mk(0,0,0,        1,0,0,0,0, 0,0,32'h0,   1,0,8'h00,0));

        foreach (tbl[i]) run(tbl[i], $sformatf("vec%0d", i));

        // Table overflow, then push+pop on a full table
        do_reset();
        for (int i = 0; i < 8; i++)
            run(mk(1,32'h4000+32'(i)*32'h100,0, 0,0,0,0,0,
                   0,0,0, 4'(i+1),0,8'h00,0), $sformatf("fill%0d", i));
        run(mk(1,32'h4800,0, 0,0,0,0,0, 0,0,0, 8,1,8'h20,0), "tfull");
        run(mk(0,0,0,        0,0,0,0,1, 0,0,0, 8,0,8'h00,0), "tfull_ack");
        run(mk(1,32'h4900,4, 1,0,0,0,0, 1,1,32'h4000,8,0,8'h00,0), "pushpop");
        run(mk(0,0,0,        0,1,0,0,0, 0,0,0, 8,1,8'h04,0), "tf_disarm");

        // Coalescing: three buffers of 2, no ack, then ack with disarm
        do_reset();
        for (int i = 0; i < 4; i++)
            run(mk(1,32'h5000+32'(i)*32'h1000,0, 0,0,0,0,0,
                   0,0,0, 4'(i+1),0,8'h00,0), $sformatf("push%0d", i));
        run(mk(0,0,2, 1,0,0,0,0, 1,1,32'h5000,3,0,8'h00,0), "c_arm");
        for (int i = 0; i < 5; i++) begin
            beat_i = 1;
            @(posedge clk_i);
            @(negedge clk_i);
            idle_inputs();
        end
        run(mk(0,0,0, 0,0,0,1,0, 1,1,32'h8000,0,1,8'h11,2), "c_lost");
        run(mk(0,0,0, 0,1,0,0,1, 0,0,0,        0,1,8'h04,0), "c_ackdis");

        // Asynchronous reset mid-buffer with an interrupt pending
        do_reset();
        run(mk(0,0,8,        1,0,0,0,0, 0,0,0,        0,1,8'h08,0), "r_under");
        run(mk(1,32'h8000,0, 0,0,0,0,0, 0,0,0,        1,1,8'h08,0), "r_push");
        run(mk(0,0,8,        1,0,0,0,0, 1,1,32'h8000,0,1,8'h08,0), "r_arm");
        run(mk(0,0,0,        0,0,0,1,0, 1,1,32'h8004,0,1,8'h08,0), "r_b1");
        run(mk(0,0,0,        0,0,0,1,0, 1,1,32'h8008,0,1,8'h08,0), "r_b2");
        run(mk(0,0,0,        0,0,0,1,0, 1,1,32'h800C,0,1,8'h08,0), "r_b3");
        #2;
        reset_i = 1;
        #1;
        chk_zero("async_rst");
        @(negedge clk_i);
        reset_i = 0;
        run(mk(0,0,8, 1,0,0,0,0, 0,0,0, 0,1,8'h08,0), "r_rearm");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pcap_buffer_ctrl.md
# pcap_buffer_ctrl

Parametrised DMA buffer-table controller for position capture (PCAP). It holds a FIFO of host-supplied buffer base addresses and generates the running DMA write address for each captured word. It raises an interrupt with flags and a sample count whenever a buffer fills, capture completes, the capture is disarmed or the address table runs dry. It sits between the PCAP register block and the AXI HP DMA write engine. It generalises the former single-buffer, fixed-size scheme to a configurable table depth and block size, adds interrupt coalescing, and adds lost-interrupt reporting.

## Interface
Parameters:
- AW, 3: address FIFO depth is 2**AW entries.
- BLKW, 16: width of the block-size and sample-count fields.

Clock and reset: one clock; reset is asynchronous and active-high.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  asynchronous, active-high reset
- addr_wr_i  in  1  push addr_i into the address FIFO
- addr_i  in  32  buffer base address; bits [1:0] ignored (treated as 0)
- block_words_i  in  BLKW  words per buffer; sampled on an accepted arm
- arm_i  in  1  start-capture pulse
- disarm_i  in  1  abort-capture pulse
- end_i  in  1  capture-completed pulse
- beat_i  in  1  one 32-bit word accepted by the DMA engine
- irq_ack_i  in  1  host acknowledge of the pending interrupt
- active_o  out  1  capture buffer open
- dma_addr_o  out  32  address for the next beat
- addr_level_o  out  AW+1  FIFO occupancy
- irq_o  out  1  interrupt pending (level)
- irq_flags_o  out  8  [0] BLOCK_DONE, [1] COMPLETED, [2] DISARMED, [3] UNDERRUN, [4] IRQ_LOST, [5] TABLE_FULL, [7:6] zero
- irq_count_o  out  BLKW  words written into the buffer just closed

## Operation
State machine with two states, IDLE and ACTIVE.

IDLE:
- arm_i with block_words_i = 0 is ignored.
- arm_i with the FIFO empty raises an event with UNDERRUN, count 0; the state stays IDLE.
- Otherwise arm_i pops the FIFO head into base, latches block_words_i, clears count, and moves to ACTIVE.

ACTIVE, each cycle:
- Priority: disarm_i > end_i > beat_i.
- disarm_i raises DISARMED with the current count and returns to IDLE; a beat_i in the same cycle is discarded.
- end_i raises COMPLETED with count+beat_i and returns to IDLE.
- beat_i increments count. When the incremented count equals the latched block size, BLOCK_DONE is raised with count = block size. Then:
  - FIFO non-empty: pop the next base and clear count in the same cycle; the state stays ACTIVE.
  - FIFO empty: the same event also sets UNDERRUN, and the state returns to IDLE.
- arm_i is ignored.

Address arithmetic:
- dma_addr_o = base + (count << 2), modulo 2**32; the wrap is unflagged.

Address FIFO:
- A push when full is dropped and raises an event with TABLE_FULL, count 0.
- A push and a pop in the same cycle both succeed, including when the FIFO is full.
- Pop order is first-in, first-out.

Interrupt coalescing:
- An event while irq_o = 0 loads the flags and count, and sets irq_o.
- An event while irq_o = 1 ORs its flags into irq_flags_o, sets IRQ_LOST and overwrites irq_count_o.
- irq_ack_i clears irq_o, irq_flags_o and irq_count_o.
- irq_ack_i together with a new event: the new event loads fresh (no OR, no IRQ_LOST) and irq_o stays 1.
- Two events in one cycle (e.g. BLOCK_DONE and UNDERRUN, or TABLE_FULL with any state event) merge into a single event; this is not a loss.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE; active_o = 0 and dma_addr_o = 0 immediately on reset assertion.
- active_o, dma_addr_o and addr_level_o are registered and reflect inputs one cycle after the triggering edge.
- An arm on cycle N gives active_o = 1 and dma_addr_o = base on N+1. The first beat can be presented on N+1.
- A beat on cycle N gives dma_addr_o = base + 4 on N+1.
- On a rollover beat at N, dma_addr_o equals the new base at N+1, so back-to-back beats incur no bubble.
- Events are registered: an event cycle N gives irq_o, irq_flags_o and irq_count_o valid on N+1.
- An ack on N gives irq_o = 0 on N+1.
- Reset mid-capture: state IDLE, FIFO flushed, pending interrupt discarded.

## Test plan
- Push 0x1000 and 0x2000, block 4, arm, 8 beats -> dma_addr_o sequence 0x1000..0x100C, 0x2000..0x200C. Two BLOCK_DONE, each count 4; the second also has UNDERRUN; active_o = 0; no bubble at the rollover.
- Push 0x1000, block 16, arm, 5 beats, then end_i coincident with a 6th beat -> flags 0x02, count 6, active_o = 0.
- Arm with the FIFO empty -> flags 0x08, count 0, active_o stays 0. Then ack -> irq_o = 0 next cycle.
- Push 9 addresses with AW = 3 -> level 8, flags 0x20. Then push and pop in the same full cycle -> level stays 8, no TABLE_FULL.
- Block 2, three buffers, no ack -> flags 0x11 (BLOCK_DONE with IRQ_LOST set), count 2. Ack coincident with disarm_i -> flags 0x04, irq_o held at 1.
- Assert reset_i mid-buffer (count 3) -> all outputs 0 asynchronously, level 0. A re-arm afterwards raises UNDERRUN.
